// File: rtl/ws2812_frame_tx.sv
// ---------------------------------------------------------------------------
// ws2812_frame_tx
//
// Serialises one frame of NUM_LED 24-bit pixels onto a WS2812-style single
// wire LED data line. A start request in IDLE snapshots the whole pixel bus,
// the pixels are then sent pixel 0 first, each word MSB first, using
// pulse-width coding (T0H / T1H high cycles out of T_BIT), followed by a
// T_RES-cycle low latch gap and a one-cycle done pulse.
//
// Ports:
//   sys_clk        system clock
//   sys_rst        synchronous active-high reset
//   start          frame request, only honoured in IDLE
//   pic_flattened  pixel i at bits [(i+1)*24-1 : i*24]
//   busy           high while a frame or its latch gap is in progress
//   done           one-cycle pulse in the first IDLE cycle after the gap
//   led_dout       registered serial data line
// ---------------------------------------------------------------------------
module ws2812_frame_tx #(
    parameter int NUM_LED = 64,
    parameter int T_BIT   = 60,
    parameter int T0H     = 15,
    parameter int T1H     = 45,
    parameter int T_RES   = 15000
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   start,
    input  logic [24*NUM_LED-1:0]  pic_flattened,
    output logic                   busy,
    output logic                   done,
    output logic                   led_dout
);

    localparam int LW = (NUM_LED > 1) ? $clog2(NUM_LED) : 1;
    localparam int CW = $clog2(T_BIT);
    localparam int BW = 5;
    localparam int RW = (T_RES > 1) ? $clog2(T_RES) : 1;

    localparam logic [CW-1:0] CYC_LAST = CW'(T_BIT - 1);
    localparam logic [CW-1:0] T0H_C    = CW'(T0H);
    localparam logic [CW-1:0] T1H_C    = CW'(T1H);
    localparam logic [BW-1:0] BIT_LAST = 5'd23;
    localparam logic [LW-1:0] LED_LAST = LW'(NUM_LED - 1);
    localparam logic [RW-1:0] RES_LAST = RW'(T_RES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    state_t                    state_r, state_s;
    logic [LW-1:0]             cnt_led_r, cnt_led_s;
    logic [BW-1:0]             cnt_bit_r, cnt_bit_s;
    logic [CW-1:0]             cnt_cyc_r, cnt_cyc_s;
    logic [RW-1:0]             cnt_res_r, cnt_res_s;
    logic [NUM_LED-1:0][23:0]  shadow_r;
    logic [NUM_LED-1:0][23:0]  pic_s;
    logic                      shadow_load_s;
    logic                      nbit_s;
    logic                      led_s;
    logic                      busy_s;
    logic                      done_s;
    logic                      led_dout_r;
    logic                      busy_r;
    logic                      done_r;

    // Pixel-indexed view of the flat input bus.
    assign pic_s = pic_flattened;

    // Next-state, counter and output decode; outputs are computed for the
    // next cycle so that the registered line matches the counters it follows.
    always_comb begin
        state_s       = state_r;
        cnt_led_s     = cnt_led_r;
        cnt_bit_s     = cnt_bit_r;
        cnt_cyc_s     = cnt_cyc_r;
        cnt_res_s     = cnt_res_r;
        shadow_load_s = 1'b0;
        nbit_s        = 1'b0;
        busy_s        = 1'b0;
        done_s        = 1'b0;
        led_s         = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s       = ST_SEND;
                    cnt_led_s     = '0;
                    cnt_bit_s     = '0;
                    cnt_cyc_s     = '0;
                    shadow_load_s = 1'b1;
                    busy_s        = 1'b1;
                    // Shadow is loaded on this same edge, so take the first
                    // bit straight from the bus.
                    nbit_s        = pic_s[0][23];
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                busy_s = 1'b1;
                if (cnt_cyc_r == CYC_LAST) begin
                    cnt_cyc_s = '0;
                    if (cnt_bit_r == BIT_LAST) begin
                        cnt_bit_s = '0;
                        if (cnt_led_r == LED_LAST) begin
                            state_s   = ST_LATCH;
                            cnt_led_s = '0;
                            cnt_res_s = '0;
                        end else begin
                            cnt_led_s = cnt_led_r + LW'(1);
                        end
                    end else begin
                        cnt_bit_s = cnt_bit_r + BW'(1);
                    end
                end else begin
                    cnt_cyc_s = cnt_cyc_r + CW'(1);
                end
                nbit_s = shadow_r[cnt_led_s][BIT_LAST - cnt_bit_s];
            end
            ST_LATCH: begin
                busy_s = 1'b1;
                if (cnt_res_r == RES_LAST) begin
                    state_s   = ST_IDLE;
                    cnt_res_s = '0;
                    busy_s    = 1'b0;
                    done_s    = 1'b1;
                end else begin
                    cnt_res_s = cnt_res_r + RW'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // High phase of the bit occupies the first T0H/T1H cycles of its slot.
        if (state_s == ST_SEND) begin
            led_s = (cnt_cyc_s < (nbit_s ? T1H_C : T0H_C));
        end else begin
            led_s = 1'b0;
        end
    end

    // State, counters, frame snapshot and registered outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r    <= ST_IDLE;
            cnt_led_r  <= '0;
            cnt_bit_r  <= '0;
            cnt_cyc_r  <= '0;
            cnt_res_r  <= '0;
            shadow_r   <= '0;
            led_dout_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_led_r  <= cnt_led_s;
            cnt_bit_r  <= cnt_bit_s;
            cnt_cyc_r  <= cnt_cyc_s;
            cnt_res_r  <= cnt_res_s;
            led_dout_r <= led_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            if (shadow_load_s) begin
                shadow_r <= pic_s;
            end
        end
    end

    assign led_dout = led_dout_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_ws2812_frame_tx.sv
// ---------------------------------------------------------------------------
// Directed testbench for ws2812_frame_tx with reduced timing parameters so a
// whole frame is a few hundred cycles. Every bit slot is decoded against the
// expected pulse shape derived from the bench's own copy of the frame.
// ---------------------------------------------------------------------------
module tb_ws2812_frame_tx;

    localparam int NL    = 4;
    localparam int TB    = 8;
    localparam int T0    = 2;
    localparam int T1    = 5;
    localparam int TR    = 20;
    localparam int NBITS = NL * 24;
    localparam int FW    = NL * 24;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          start;
    logic [FW-1:0] pic;
    logic          busy;
    logic          done;
    logic          led_dout;

    int n_assert = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    ws2812_frame_tx #(
        .NUM_LED (NL),
        .T_BIT   (TB),
        .T0H     (T0),
        .T1H     (T1),
        .T_RES   (TR)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .start         (start),
        .pic_flattened (pic),
        .busy          (busy),
        .done          (done),
        .led_dout      (led_dout)
    );

    always #5 sys_clk = ~sys_clk;

    // Count done pulses independently of the directed sequence.
    always @(negedge sys_clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle; returns at the negedge of the first SEND cycle.
    task automatic start_frame();
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    // Decode one frame starting at its first SEND cycle. 'disturb' rewrites the
    // bus and pulses start mid-frame and mid-gap; 'chain' requests the next
    // frame in the done cycle.
    task automatic check_frame(input logic [FW-1:0] exp, input bit disturb, input bit chain);
        int  bad_bits;
        int  busy_bad;
        int  latch_bad;
        int  exp_w;
        bit  bit_err;
        logic exp_led;
        bad_bits  = 0;
        busy_bad  = 0;
        latch_bad = 0;
        for (int b = 0; b < NBITS; b++) begin
            bit_err = 1'b0;
            exp_w   = exp[(b / 24) * 24 + 23 - (b % 24)] ? T1 : T0;
            for (int c = 0; c < TB; c++) begin
                exp_led = (c < exp_w) ? 1'b1 : 1'b0;
                if (led_dout !== exp_led) bit_err = 1'b1;
                if (busy !== 1'b1 || done !== 1'b0) busy_bad++;
                if (disturb && b == 40 && c == 0) begin
                    pic   = '1;
                    start = 1'b1;
                end else if (disturb && b == 40 && c == 1) begin
                    start = 1'b0;
                end
                @(negedge sys_clk);
            end
            if (bit_err) bad_bits++;
        end
        chk("bit slots with wrong pulse", bad_bits, 0);
        chk("busy/done during send", busy_bad, 0);
        for (int c = 0; c < TR; c++) begin
            if (led_dout !== 1'b0 || busy !== 1'b1 || done !== 1'b0) latch_bad++;
            if (disturb && c == 5) start = 1'b1;
            if (disturb && c == 6) start = 1'b0;
            @(negedge sys_clk);
        end
        chk("latch gap cycles wrong", latch_bad, 0);
        chk("done in first idle cycle", done, 1);
        chk("busy low in done cycle", busy, 0);
        chk("line low in done cycle", led_dout, 0);
        if (chain) begin
            start_frame();
        end else begin
            @(negedge sys_clk);
            chk("done lasts one cycle", done, 0);
        end
    endtask

    initial begin : main
        logic [FW-1:0] exp_a;
        logic [FW-1:0] exp_b;
        logic [FW-1:0] exp_s;
        int            idle_bad;
        int            d0;

        exp_a = 96'hA5F00F_123456_FFFFFF_800001;
        exp_b = 96'h000000_C3C3C3_5A5A5A_0F0F0F;

        sys_rst = 1'b1;
        start   = 1'b0;
        pic     = '0;
        repeat (3) @(negedge sys_clk);
        chk("reset led_dout", led_dout, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        sys_rst = 1'b0;

        // Idle with no request.
        idle_bad = 0;
        for (int i = 0; i < 200; i++) begin
            if (led_dout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) idle_bad++;
            @(negedge sys_clk);
        end
        chk("idle outputs", idle_bad, 0);

        // All-zero frame.
        d0 = done_cnt;
        pic = '0;
        start_frame();
        chk("first cycle line high", led_dout, 1);
        chk("first cycle busy", busy, 1);
        check_frame('0, 1'b0, 1'b0);
        chk("zero frame done count", done_cnt, d0 + 1);

        // Pixel 0 = 00FF00.
        pic = '0;
        pic[23:0] = 24'h00FF00;
        exp_s = pic;
        start_frame();
        check_frame(exp_s, 1'b0, 1'b0);

        // Snapshot integrity with bus rewrite and ignored start requests.
        d0 = done_cnt;
        pic = '0;
        pic[2*24 +: 24] = 24'h00FF00;
        exp_s = pic;
        start_frame();
        check_frame(exp_s, 1'b1, 1'b0);
        chk("snapshot test done count", done_cnt, d0 + 1);

        // Back-to-back frames; frame B captured in the done cycle of frame A.
        d0 = done_cnt;
        pic = exp_a;
        start_frame();
        pic = exp_b;
        check_frame(exp_a, 1'b0, 1'b1);
        check_frame(exp_b, 1'b0, 1'b0);
        chk("back-to-back done count", done_cnt, d0 + 2);

        // Reset in the middle of bit 50, then a clean full frame.
        pic = exp_a;
        start_frame();
        repeat (50 * TB + 1) @(negedge sys_clk);
        chk("mid-frame line high before reset", led_dout, 1);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        chk("reset mid-frame led_dout", led_dout, 0);
        chk("reset mid-frame busy", busy, 0);
        sys_rst = 1'b0;
        d0 = done_cnt;
        idle_bad = 0;
        for (int i = 0; i < NBITS * TB + TR + 10; i++) begin
            if (led_dout !== 1'b0 || busy !== 1'b0) idle_bad++;
            @(negedge sys_clk);
        end
        chk("abandoned frame stays idle", idle_bad, 0);
        chk("abandoned frame no done", done_cnt, d0);
        start_frame();
        check_frame(exp_a, 1'b0, 1'b0);

        // Reset and start together: reset wins.
        sys_rst = 1'b1;
        start   = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        start   = 1'b0;
        chk("reset+start busy", busy, 0);
        chk("reset+start led_dout", led_dout, 0);
        @(negedge sys_clk);
        chk("reset+start still idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ws2812_frame_tx.md
# ws2812_frame_tx

Serializes one 8x8 RGB picture (64 pixels x 24 bits) onto a WS2812-family single-wire LED data line. It sits downstream of the picture-pattern ROM, consuming its flattened `pic_flattened` bus, and is the transmitting end of the LED-matrix interface. On a start pulse it snapshots the frame, emits all pixels MSB-first with WS2812 pulse-width coding, holds the line low for the latch/reset gap, then reports completion.

## Interface

- `NUM_LED`, 64: pixels per frame.
- `T_BIT`, 60: clock cycles per data bit (1.2 us at 50 MHz).
- `T0H`, 15: high cycles for a 0 bit (0.3 us).
- `T1H`, 45: high cycles for a 1 bit (0.9 us).
- `T_RES`, 15000: low cycles of the latch gap after the last bit (300 us).
- `sys_clk`  in  1  system clock; the only clock.
- `sys_rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  frame request; sampled only in IDLE.
- `pic_flattened`  in  24*NUM_LED  pixel i at bits [(i+1)*24-1 : i*24], 24-bit word sent bit 23 first.
- `busy`  out  1  high while a frame or latch gap is in progress.
- `done`  out  1  one-cycle pulse at end of latch gap.
- `led_dout`  out  1  registered serial line to the LED chain.

## Operation

- States: IDLE, SEND, LATCH.
- IDLE: `led_dout`=0, `busy`=0. If `start`=1, capture `pic_flattened` into a shadow register, clear pixel counter `cnt_led`, bit counter `cnt_bit`, and cycle counter `cnt_cyc`, then go to SEND.
- SEND: the current bit is shadow[cnt_led*24 + 23 - cnt_bit]. `cnt_cyc` runs 0..T_BIT-1. `led_dout` is 1 while `cnt_cyc` < (bit ? T1H : T0H), otherwise 0.
  - At `cnt_cyc`=T_BIT-1, `cnt_bit` increments. At `cnt_bit`=23 it wraps to 0 and `cnt_led` increments.
  - After the last bit of pixel NUM_LED-1, go to LATCH.
- LATCH: `led_dout`=0 for T_RES cycles. After the last cycle, pulse `done` and return to IDLE.
- Input bus changes after capture have no effect on the frame in flight, so there is no tearing.
- `start` in SEND or LATCH is ignored. No queuing.
- `start` in the cycle that `done` is high (state IDLE) is accepted, giving back-to-back frames.
- Counter widths are sized by $clog2 of their parameter. No counter may overflow past its terminal value.
- Parameter legality: 0 < T0H < T1H < T_BIT, T_RES ≥ 1, NUM_LED ≥ 1.

## Timing

- Reset values: `led_dout`=0, `busy`=0, `done`=0, state=IDLE, all counters 0, shadow cleared.
- `start` sampled at edge k:
  - `busy`=1 from edge k.
  - The first bit's high phase drives `led_dout` for cycles k..k+TxH-1.
- Each bit takes exactly T_BIT cycles. The frame data phase takes NUM_LED*24*T_BIT cycles (92160 with defaults).
- LATCH starts the cycle after the last bit's final cycle and lasts exactly T_RES cycles.
- `done`=1 for exactly one cycle, in the first IDLE cycle; `busy`=0 in that same cycle.
- Start-to-done latency: NUM_LED*24*T_BIT + T_RES cycles (107160 with defaults).
- `sys_rst` asserted mid-SEND or mid-LATCH: at the next edge `led_dout`=0, `busy`=0, and state=IDLE. No `done` pulse is issued; the partial frame is abandoned.
- `sys_rst` and `start` high together: reset wins and the frame does not start.

## Test plan

- Reset then idle: hold `start`=0 for 1000 cycles -> `led_dout`=0, `busy`=0, `done` never pulses.
- All-zero frame, NUM_LED=64 defaults, one `start` pulse:
  - 1536 high pulses of 15 cycles each, on a 60-cycle pitch.
  - Then 15000 low cycles.
  - `done` pulses once, 107160 cycles after the start sample.
- Single-bit decode: pixel 0 = 24'h00FF00, rest 0. Pixel 0 pulse widths read 15 x8, 45 x8, 15 x8; all remaining pulses are 15.
- Snapshot and ignore:
  - Start with pixel 25 = 24'h00FF00.
  - Change `pic_flattened` to all 24'hFFFFFF mid-frame and pulse `start` during SEND and during LATCH.
  - Required: the original frame is decoded intact and exactly one `done` pulse occurs.
- Back-to-back: assert `start` in the `done` cycle -> the next frame's first high phase begins that cycle, with no gap beyond T_RES.
- Reset mid-frame: assert `sys_rst` at bit 700 -> next cycle `led_dout`=0, `busy`=0. No `done` pulse. A subsequent `start` sends the full 1536 bits.
